// File: rtl/fp32_divider_pkg.sv
// fp32_pkg: shared definitions for the binary32 divider.
// Holds the format constants, the controller state encoding, and a small
// operand classifier used by the special-case logic.
// No ports (package).
package fp32_pkg;

    localparam int          EXP_BIAS  = 127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam int          MANT_W    = 24;
    localparam int          QUOT_BITS = 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FP_ZERO   = 2'd0,
        FP_INF    = 2'd1,
        FP_NAN    = 2'd2,
        FP_NORMAL = 2'd3
    } fp_class_e;

    // Subnormals (exponent 0) are deliberately reported as zero so the
    // datapath never has to handle a missing hidden bit.
    function automatic fp_class_e classify_fp32(input logic [31:0] x);
        fp_class_e cls;
        if (x[30:23] == 8'h00)
            cls = FP_ZERO;
        else if (x[30:23] == EXP_MAX)
            cls = (x[22:0] == 23'h0) ? FP_INF : FP_NAN;
        else
            cls = FP_NORMAL;
        return cls;
    endfunction

endpackage

// File: rtl/fp32_divider_if.sv
// fp32_divider_if: start/done handshake and operand/result bus of the divider.
//   start, a_operand, b_operand : issued by the requester (master)
//   busy, done, result, exception : returned by the divider (slave)
interface fp32_divider_if;

    logic        start;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        exception;

    modport master (
        output start, a_operand, b_operand,
        input  busy, done, result, exception
    );

    modport slave (
        input  start, a_operand, b_operand,
        output busy, done, result, exception
    );

endinterface

// File: rtl/fp32_divider_mant_div.sv
// fp32_mant_div: bit-serial restoring divider for the significands.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture dividend/divisor and restart the iteration
//   dividend  : 25-bit aligned dividend (always in [divisor, 2*divisor))
//   divisor   : 24-bit divisor with hidden bit set
//   quotient  : 26 quotient bits, MSB is the integer bit
//   sticky    : final partial remainder is nonzero
//   valid     : all 26 bits have been produced
module fp32_mant_div
    import fp32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [MANT_W:0]      dividend,
    input  logic [MANT_W-1:0]    divisor,
    output logic [QUOT_BITS-1:0] quotient,
    output logic                 sticky,
    output logic                 valid
);

    logic [25:0]       rem;
    logic [MANT_W-1:0] dvs;
    logic [4:0]        cnt;

    // One quotient bit per clock: trial-subtract, keep the difference when it
    // does not go negative, then shift the partial remainder left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= 5'(QUOT_BITS);
            quotient <= '0;
        end else if (load) begin
            rem      <= {1'b0, dividend};
            dvs      <= divisor;
            cnt      <= '0;
            quotient <= '0;
        end else if (cnt != 5'(QUOT_BITS)) begin
            if (rem >= {2'b00, dvs}) begin
                rem      <= (rem - {2'b00, dvs}) << 1;
                quotient <= {quotient[QUOT_BITS-2:0], 1'b1};
            end else begin
                rem      <= rem << 1;
                quotient <= {quotient[QUOT_BITS-2:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
        end
    end

    assign sticky = |rem;
    assign valid  = (cnt == 5'(QUOT_BITS));

endmodule

// File: rtl/fp32_divider.sv
// fp32_divider: sequential IEEE-754 binary32 divider, result = a / b.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fp32_divider_if.slave (start, a_operand, b_operand in;
//              busy, done, result, exception out)
// Fixed 27-cycle latency from the accepting edge to done for every operand
// class; special cases are decided at accept time and held until ROUND.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fp32_divider_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_DIVIDE = 2'(DIVIDE);
    localparam logic [1:0] S_ROUND  = 2'(ROUND);

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic              special_q;
    logic [31:0]       special_res_q;
    logic              special_exc_q;
    logic [31:0]       result_q;
    logic              exc_q;
    logic              done_q;

    logic                 load;
    fp_class_e            a_cls, b_cls;
    logic [MANT_W-1:0]    ma, mb;
    logic                 d;
    logic [MANT_W:0]      dividend;
    logic signed [9:0]    exp_calc;
    logic                 spec_hit;
    logic [31:0]          spec_res;
    logic                 spec_exc;
    logic                 sign_calc;

    logic [QUOT_BITS-1:0] quot;
    logic                 sticky;
    logic                 div_valid;

    logic                 round_up;
    logic [MANT_W:0]      mant_sum;
    logic signed [9:0]    exp_rnd;
    logic [31:0]          norm_res;
    logic                 norm_exc;

    assign load      = (state == S_IDLE) && bus.start;
    assign a_cls     = classify_fp32(bus.a_operand);
    assign b_cls     = classify_fp32(bus.b_operand);
    assign sign_calc = bus.a_operand[31] ^ bus.b_operand[31];

    // Pre-normalise so the quotient's integer bit is always 1; d records the
    // extra shift so the exponent can be compensated.
    assign ma       = {1'b1, bus.a_operand[22:0]};
    assign mb       = {1'b1, bus.b_operand[22:0]};
    assign d        = (ma < mb);
    assign dividend = d ? {ma, 1'b0} : {1'b0, ma};
    assign exp_calc = 10'(bus.a_operand[30:23]) - 10'(bus.b_operand[30:23])
                    + 10'(EXP_BIAS) - 10'(d);

    // Special operand combinations, checked in priority order: NaN first,
    // then infinite results, then zero results.
    always_comb begin
        spec_hit = 1'b1;
        spec_res = QNAN;
        spec_exc = (bus.a_operand[30:23] == EXP_MAX) ||
                   (bus.b_operand[30:23] == EXP_MAX) || (b_cls == FP_ZERO);
        if (a_cls == FP_NAN || b_cls == FP_NAN ||
            (a_cls == FP_ZERO && b_cls == FP_ZERO) ||
            (a_cls == FP_INF && b_cls == FP_INF))
            spec_res = QNAN;
        else if (a_cls == FP_INF || b_cls == FP_ZERO)
            spec_res = {sign_calc, EXP_MAX, 23'h0};
        else if (b_cls == FP_INF || a_cls == FP_ZERO)
            spec_res = {sign_calc, 31'h0};
        else
            spec_hit = 1'b0;
    end

    fp32_mant_div u_mant_div (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .dividend (dividend),
        .divisor  (mb),
        .quotient (quot),
        .sticky   (sticky),
        .valid    (div_valid)
    );

    // Round to nearest even: quot[1] is the half bit, quot[0] plus the
    // remainder form the sticky information below it.
    always_comb begin
        round_up = quot[1] & (quot[0] | sticky | quot[2]);
        mant_sum = {1'b0, quot[QUOT_BITS-1:2]} + 25'(round_up);
        exp_rnd  = exp_q + 10'(mant_sum[MANT_W]);
        norm_exc = 1'b0;
        if (exp_rnd >= 10'sd255) begin
            norm_res = {sign_q, EXP_MAX, 23'h0};
            norm_exc = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
            norm_res = {sign_q, 31'h0};
        end else begin
            norm_res = {sign_q, exp_rnd[7:0],
                        mant_sum[MANT_W] ? 23'h0 : mant_sum[22:0]};
        end
    end

    // Controller: capture on accept, count 26 divide cycles, then pack the
    // answer in ROUND and pulse done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            special_exc_q <= 1'b0;
            result_q      <= '0;
            exc_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state         <= S_DIVIDE;
                        cnt           <= '0;
                        sign_q        <= sign_calc;
                        exp_q         <= exp_calc;
                        special_q     <= spec_hit;
                        special_res_q <= spec_res;
                        special_exc_q <= spec_exc;
                    end
                end
                S_DIVIDE: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(QUOT_BITS - 1))
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    state    <= S_IDLE;
                    done_q   <= div_valid;
                    result_q <= special_q ? special_res_q : norm_res;
                    exc_q    <= special_q ? special_exc_q : norm_exc;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.exception = exc_q;

endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: scoreboard bench for fp32_divider.
// Stimulus pushes the reference answer and issue cycle into a queue; a
// separate monitor pops on every done and compares result, exception and
// latency. The reference divides with wide integer arithmetic and rounds
// by comparing the discarded part against one half.
module tb_fp32_divider;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          issue;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle;
    int   checks;
    int   failures;
    exp_t sb[$];

    fp32_divider_if bus();

    fp32_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference quotient: exact integer division, explicit RNE, then range
    // and special-value rules.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned fa, fb, ma, mb, num, q, r, mant, lo, half;
        bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, exc;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = longint'(a[22:0]);
        fb = longint'(b[22:0]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        exc    = (ea == 255) || (eb == 255) || b_zero;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            return {exc, 32'h7FC00000};
        if (a_inf || b_zero)
            return {exc, s, 8'hFF, 23'h0};
        if (b_inf || a_zero)
            return {exc, s, 31'h0};
        ma  = fa + (64'd1 << 23);
        mb  = fb + (64'd1 << 23);
        num = ma << 26;
        q   = num / mb;
        r   = num % mb;
        e   = ea - eb + 127;
        if (q >= (64'd1 << 26)) begin
            sh = 3;
        end else begin
            sh = 2;
            e  = e - 1;
        end
        mant = q >> sh;
        lo   = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (lo > half || (lo == half && (r != 0 || mant[0])))
            mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255)
            return {1'b1, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {1'b0, s, 31'h0};
        return {1'b0, s, 8'(e), mant[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h, expected %08h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Issue one divide, then watch busy until done; restart_at >= 0 pulses a
    // second start (with different operands) that must be ignored.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int restart_at);
        exp_t        e;
        logic [32:0] r;
        bit          busy_ok;
        bit          seen;
        @(negedge clk);
        r = ref_div(a, b);
        bus.a_operand = a;
        bus.b_operand = b;
        bus.start     = 1'b1;
        e.res   = r[31:0];
        e.exc   = r[32];
        e.issue = cycle + 1;
        sb.push_back(e);
        busy_ok = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == restart_at) begin
                bus.start     = 1'b1;
                bus.a_operand = 32'h40400000;
                bus.b_operand = 32'h3F800000;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        bus.start = 1'b0;
        checkOutput("done_seen", 32'(seen), 32'd1);
        checkOutput("busy_held", 32'(busy_ok), 32'd1);
        @(negedge clk);
        checkOutput("done_pulse_len", 32'(bus.done), 32'd0);
        checkOutput("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got result %08h, expected no done", bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("result", bus.result, e.res);
                checkOutput("exception", 32'(bus.exception), 32'(e.exc));
                checkOutput("latency", 32'(cycle - e.issue), 32'd27);
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        checks   = 0;
        failures = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.a_operand = '0;
        bus.b_operand = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_result", bus.result, 32'h0);
        checkOutput("reset_exception", 32'(bus.exception), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(32'h3F800000, 32'h40000000, -1);
        applyStimulus(32'h40C00000, 32'h40400000, -1);
        applyStimulus(32'hC0F00000, 32'h40200000, -1);
        applyStimulus(32'h3F800000, 32'h40400000, -1);
        applyStimulus(32'h3F800000, 32'h3F800000, -1);
        applyStimulus(32'h3F800000, 32'h00000000, -1);
        applyStimulus(32'h00000000, 32'h00000000, -1);
        applyStimulus(32'h7FC00000, 32'h3F800000, -1);
        applyStimulus(32'h7F800000, 32'hC0000000, -1);
        applyStimulus(32'h00000000, 32'h40000000, -1);
        applyStimulus(32'h7F7FFFFF, 32'h00800000, -1);
        applyStimulus(32'h00800000, 32'h4B000000, -1);
        applyStimulus(32'h40000000, 32'h7F800000, -1);
        applyStimulus(32'h7F800000, 32'hFF800000, -1);
        applyStimulus(32'h00400000, 32'h40000000, -1);

        // Second start during the operation must not disturb it.
        applyStimulus(32'h40E00000, 32'h40000000, 9);

        // Reset in the middle of a divide aborts it without a done.
        @(negedge clk);
        bus.a_operand = 32'h41200000;
        bus.b_operand = 32'h40A00000;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("busy_before_abort", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_result", bus.result, 32'h0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Random normal operands, with a share of extreme exponents so the
        // overflow and flush-to-zero paths are exercised too.
        for (int n = 0; n < 300; n++) begin
            ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            if (n % 10 == 3) ra[30:23] = 8'($urandom_range(200, 254));
            if (n % 10 == 3) rb[30:23] = 8'($urandom_range(1, 60));
            if (n % 10 == 7) ra[30:23] = 8'($urandom_range(1, 60));
            if (n % 10 == 7) rb[30:23] = 8'($urandom_range(200, 254));
            if (n % 10 == 5) rb[22:0]  = ra[22:0];
            applyStimulus(ra, rb, -1);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
